pwm_duty_ramp_ctrl: RTL
=======================

# pwm_duty_ramp_ctrl

Duty-cycle sequencer between the SPI register bank and the PWM peripheral. It takes the duty-cycle target written over SPI and moves the PWM duty-cycle register toward it in fixed steps at a programmable cadence, so loads see a soft ramp instead of an instant jump. Its output drives the PWM peripheral's duty-cycle input directly. Handshake outputs report ramp progress to the top level.

## Interface
- DUTY_W, 8, width of duty-cycle values
- STEP, 1, duty change per step, 1..2^DUTY_W-1
- PERIOD_W, 16, width of the step-period field
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  reset, asynchronous, active-high
- target_duty  input  DUTY_W  requested duty cycle from the SPI register bank
- target_valid  input  1  one-cycle strobe: target_duty was just written
- ramp_en  input  1  1 = ramp toward the target; 0 = apply the target immediately
- step_period  input  PERIOD_W  clocks between steps (N); 0 is treated as 1
- pwm_duty_cycle  output  DUTY_W  current duty cycle for the PWM peripheral
- busy  output  1  high while a ramp is in progress
- done  output  1  one-cycle pulse when pwm_duty_cycle reaches the accepted target

## Operation
- States:
  - IDLE: no ramp in progress.
  - RAMP: duty is stepping toward the target.
- Internal registers: tgt (DUTY_W), cnt (PERIOD_W).
- Reset (asynchronous, while rst=1):
  - state=IDLE, pwm_duty_cycle=0, tgt=0, cnt=0, busy=0, done=0.
- IDLE, target_valid=1 on edge E0: tgt<=target_duty, then one of:
  - ramp_en=0 or target_duty==pwm_duty_cycle: pwm_duty_cycle<=target_duty and done<=1 on E0; stay in IDLE.
  - Otherwise: go to RAMP, busy<=1, cnt<=N-1.
- RAMP, on each edge:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: take one step and reload cnt<=N-1. step_period is sampled only at reload.
- Step arithmetic, computed at DUTY_W+1 bits with no wrap:
  - Upward: new=min(duty+STEP, tgt).
  - Downward: new=max(duty-STEP, tgt).
  - Direction is recomputed every step from the sign of tgt-duty.
- Ramp completion: when a step makes the duty equal tgt, on that same edge:
  - done<=1, busy<=0, state<=IDLE.
- target_valid=1 while in RAMP (retarget):
  - tgt<=target_duty; cnt is not reloaded, so the step cadence is kept.
  - If the new target equals the current duty: done<=1, busy<=0, IDLE.
- ramp_en falls to 0 in RAMP, sampled at an edge:
  - pwm_duty_cycle<=tgt, done<=1, busy<=0, IDLE on that edge.
- target_valid on the same edge as the final step:
  - The new target wins. tgt is updated and the step uses the old tgt.
  - done is suppressed. Stay in RAMP unless the stepped duty equals the new target; in that case done<=1 and go to IDLE.
- ramp_en=0 together with target_valid in RAMP: jump to target_duty (the new value).
- done is registered and is high for exactly one cycle per completion.

## Timing
- Immediate apply: the new duty is visible right after edge E0, with done high in the cycle after E0. Latency is 1 clock from the strobe.
- Ramp: the k-th step is visible after edge E0+k·N, with N=max(step_period,1).
  - busy is high from after E0 until after the final-step edge.
  - done is high for the single cycle after the final-step edge.
- A ramp of distance D takes ceil(D/STEP) steps, so ceil(D/STEP)·N clocks.
- rst asserted mid-ramp: all outputs go to their reset values immediately, with no clock needed. The first accepted strobe after release starts from duty 0.
- target_valid while rst=1 is ignored.

## Test plan
- Reset: assert rst mid-simulation with no clock running -> pwm_duty_cycle=0x00, busy=0, done=0 at once.
- Immediate apply: ramp_en=0, strobe target 0x80 from duty 0 -> duty=0x80 one clock later, one done pulse, busy never high.
- Up ramp: STEP=1, step_period=4, ramp_en=1, strobe target 0x03 at E0 -> duty 1, 2, 3 after E0+4, E0+8, E0+12; busy high from E0 to E0+12; a single done after E0+12.
- Clamp, down ramp: STEP=16, period=1, duty at 0x25, strobe target 0x00 -> duty 0x15, 0x05, 0x00 on consecutive clocks, no underflow, done after the third step.
- Retarget: STEP=1, period=2, ramping 0x00->0x10; at duty 0x04 strobe target 0x02 -> duty 0x03, 0x02 on the next two step edges, cadence unchanged, exactly one done (at 0x02).
- Abort and reset: during a ramp to 0x40, drop ramp_en -> duty=0x40 next clock and done pulses. Repeat the ramp and assert rst at duty 0x10 -> duty=0x00 and busy=0 immediately, with no done.

Source files
------------

// File: rtl/pwm_duty_ramp_ctrl.sv
// pwm_duty_ramp_ctrl: ramps the PWM duty-cycle register toward an SPI-written target in fixed steps.
module pwm_duty_ramp_ctrl #(
  parameter int DUTY_W   = 8,
  parameter int STEP     = 1,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DUTY_W-1:0]   target_duty,
  input  logic                target_valid,
  input  logic                ramp_en,
  input  logic [PERIOD_W-1:0] step_period,
  output logic [DUTY_W-1:0]   pwm_duty_cycle,
  output logic                busy,
  output logic                done
);
  typedef enum logic {IDLE, RAMP} state_t;
  localparam logic [DUTY_W:0] STP = (DUTY_W+1)'(STEP);
  state_t state, state_n;
  logic [DUTY_W-1:0] tgt, tgt_n, duty_n, stepped;
  logic [PERIOD_W-1:0] cnt, cnt_n, reload;
  logic [DUTY_W:0] d, t, up, dn;
  logic busy_n, done_n;
  // Step math is one bit wider so neither direction can wrap before clamping to tgt.
  always_comb begin
    reload  = step_period == '0 ? '0 : step_period - PERIOD_W'(1);
    d       = {1'b0, pwm_duty_cycle};
    t       = {1'b0, tgt};
    up      = d + STP;
    dn      = d - STP;
    stepped = t > d ? (up >= t ? tgt : up[DUTY_W-1:0]) : (d >= t + STP ? dn[DUTY_W-1:0] : tgt);
    state_n = state;
    tgt_n   = tgt;
    cnt_n   = cnt;
    duty_n  = pwm_duty_cycle;
    busy_n  = busy;
    done_n  = 1'b0;
    if (state == IDLE) begin
      if (target_valid) begin
        tgt_n = target_duty;
        if (!ramp_en || target_duty == pwm_duty_cycle) begin
          duty_n = target_duty;
          done_n = 1'b1;
        end else begin
          state_n = RAMP;
          busy_n  = 1'b1;
          cnt_n   = reload;
        end
      end
    end else if (!ramp_en) begin
      duty_n  = target_valid ? target_duty : tgt;
      tgt_n   = duty_n;
      done_n  = 1'b1;
      busy_n  = 1'b0;
      state_n = IDLE;
    end else begin
      tgt_n  = target_valid ? target_duty : tgt;
      duty_n = target_valid && target_duty == pwm_duty_cycle ? pwm_duty_cycle :
               cnt == '0 ? stepped : pwm_duty_cycle;
      cnt_n  = cnt == '0 ? reload : cnt - PERIOD_W'(1);
      if (duty_n == tgt_n) begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pwm_duty_cycle <= '0;
      tgt            <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_n;
      pwm_duty_cycle <= duty_n;
      tgt            <= tgt_n;
      cnt            <= cnt_n;
      busy           <= busy_n;
      done           <= done_n;
    end
  end
endmodule
